// File: rtl/cosim_commit_queue.sv
// Retirement event queue feeding the co-simulation checker: per-cycle commits and
// an optional trap are compacted in program order into a FIFO and drained one per cycle.
module cosim_commit_queue #(
  parameter int unsigned COMMITS = 2,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [COMMITS-1:0]        commit_valid,
  input  logic [COMMITS*XLEN-1:0]   commit_pc,
  input  logic [COMMITS*32-1:0]     commit_insn,
  input  logic [COMMITS-1:0]        commit_wen,
  input  logic [COMMITS-1:0]        commit_wfp,
  input  logic [COMMITS*5-1:0]      commit_waddr,
  input  logic [COMMITS*XLEN-1:0]   commit_wdata,
  input  logic                      trap_valid,
  input  logic [XLEN-1:0]           trap_cause,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_kind,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_insn,
  output logic                      out_wen,
  output logic                      out_wfp,
  output logic [4:0]                out_waddr,
  output logic [XLEN-1:0]           out_wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [15:0]               drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_count_q, drop_count_d;

  logic            mem_kind_q  [DEPTH];
  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [31:0]     mem_insn_q  [DEPTH];
  logic            mem_wen_q   [DEPTH];
  logic            mem_wfp_q   [DEPTH];
  logic [4:0]      mem_waddr_q [DEPTH];
  logic [XLEN-1:0] mem_wdata_q [DEPTH];

  logic [DEPTH-1:0] wr_en;
  logic            wr_kind  [DEPTH];
  logic [XLEN-1:0] wr_pc    [DEPTH];
  logic [31:0]     wr_insn  [DEPTH];
  logic            wr_wen   [DEPTH];
  logic            wr_wfp   [DEPTH];
  logic [4:0]      wr_waddr [DEPTH];
  logic [XLEN-1:0] wr_wdata [DEPTH];

  logic [CNT_W-1:0] n_events;
  logic [CNT_W-1:0] free_slots;
  logic             accept;
  logic             drop;
  logic             deq;
  logic [PTR_W-1:0] slot;
  logic [16:0]      drop_sum;

  // Group admission: all-or-nothing against occupancy at the start of the cycle.
  always_comb begin
    n_events = '0;
    for (int i = 0; i < int'(COMMITS); i++) begin
      n_events = n_events + CNT_W'(commit_valid[i]);
    end
    n_events   = n_events + CNT_W'(trap_valid);
    free_slots = CNT_W'(DEPTH) - count_q;
    accept     = reset && (n_events != '0) && (n_events <= free_slots);
    drop       = reset && (n_events > free_slots);
    deq        = out_valid && out_ready;
  end

  // Compact valid lanes into consecutive slots; the trap lands after the commits.
  always_comb begin
    wr_en = '0;
    for (int s = 0; s < int'(DEPTH); s++) begin
      wr_kind[s]  = 1'b0;
      wr_pc[s]    = '0;
      wr_insn[s]  = '0;
      wr_wen[s]   = 1'b0;
      wr_wfp[s]   = 1'b0;
      wr_waddr[s] = '0;
      wr_wdata[s] = '0;
    end
    slot = wr_ptr_q;
    if (accept) begin
      for (int i = 0; i < int'(COMMITS); i++) begin
        if (commit_valid[i]) begin
          wr_en[slot]    = 1'b1;
          wr_kind[slot]  = 1'b0;
          wr_pc[slot]    = commit_pc[i*XLEN +: XLEN];
          wr_insn[slot]  = commit_insn[i*32 +: 32];
          wr_wen[slot]   = commit_wen[i];
          wr_wfp[slot]   = commit_wfp[i];
          wr_waddr[slot] = commit_wen[i] ? commit_waddr[i*5 +: 5] : 5'd0;
          wr_wdata[slot] = commit_wen[i] ? commit_wdata[i*XLEN +: XLEN] : XLEN'(0);
          slot           = slot + PTR_W'(1);
        end
      end
      if (trap_valid) begin
        wr_en[slot]    = 1'b1;
        wr_kind[slot]  = 1'b1;
        wr_wdata[slot] = trap_cause;
      end
    end
  end

  // Pointer, occupancy and drop bookkeeping.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + (accept ? PTR_W'(n_events) : PTR_W'(0));
    rd_ptr_d     = rd_ptr_q + (deq ? PTR_W'(1) : PTR_W'(0));
    count_d      = count_q + (accept ? n_events : CNT_W'(0)) - CNT_W'(deq);
    overflow_d   = overflow_q | drop;
    drop_sum     = {1'b0, drop_count_q} + 17'(n_events);
    drop_count_d = drop_count_q;
    if (drop) begin
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Payload storage is not reset; reads are masked while empty.
  always_ff @(posedge clock) begin
    for (int s = 0; s < int'(DEPTH); s++) begin
      if (wr_en[s]) begin
        mem_kind_q[s]  <= wr_kind[s];
        mem_pc_q[s]    <= wr_pc[s];
        mem_insn_q[s]  <= wr_insn[s];
        mem_wen_q[s]   <= wr_wen[s];
        mem_wfp_q[s]   <= wr_wfp[s];
        mem_waddr_q[s] <= wr_waddr[s];
        mem_wdata_q[s] <= wr_wdata[s];
      end
    end
  end

  always_comb begin
    out_valid  = (count_q != '0);
    out_kind   = out_valid ? mem_kind_q[rd_ptr_q]  : 1'b0;
    out_pc     = out_valid ? mem_pc_q[rd_ptr_q]    : '0;
    out_insn   = out_valid ? mem_insn_q[rd_ptr_q]  : '0;
    out_wen    = out_valid ? mem_wen_q[rd_ptr_q]   : 1'b0;
    out_wfp    = out_valid ? mem_wfp_q[rd_ptr_q]   : 1'b0;
    out_waddr  = out_valid ? mem_waddr_q[rd_ptr_q] : '0;
    out_wdata  = out_valid ? mem_wdata_q[rd_ptr_q] : '0;
    count      = count_q;
    overflow   = overflow_q;
    drop_count = drop_count_q;
  end

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Randomised and directed bench for cosim_commit_queue against an event-list model.
module tb_cosim_commit_queue;

  localparam int unsigned COMMITS = 2;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned DEPTH   = 16;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [COMMITS-1:0]      commit_valid;
  logic [COMMITS*XLEN-1:0] commit_pc;
  logic [COMMITS*32-1:0]   commit_insn;
  logic [COMMITS-1:0]      commit_wen;
  logic [COMMITS-1:0]      commit_wfp;
  logic [COMMITS*5-1:0]    commit_waddr;
  logic [COMMITS*XLEN-1:0] commit_wdata;
  logic                    trap_valid;
  logic [XLEN-1:0]         trap_cause;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_kind;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_insn;
  logic                    out_wen;
  logic                    out_wfp;
  logic [4:0]              out_waddr;
  logic [XLEN-1:0]         out_wdata;
  logic [4:0]              count;
  logic                    overflow;
  logic [15:0]             drop_count;

  cosim_commit_queue #(.COMMITS(COMMITS), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_insn(commit_insn),
    .commit_wen(commit_wen), .commit_wfp(commit_wfp), .commit_waddr(commit_waddr),
    .commit_wdata(commit_wdata), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_pc(out_pc),
    .out_insn(out_insn), .out_wen(out_wen), .out_wfp(out_wfp), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        kind;
    logic [63:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic        wfp;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } ev_t;

  ev_t mq[$];
  int  m_ovf;
  int  m_drops;
  int  errors = 0;
  int  checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    commit_valid = '0; commit_pc = '0; commit_insn = '0; commit_wen = '0;
    commit_wfp = '0; commit_waddr = '0; commit_wdata = '0;
    trap_valid = 1'b0; trap_cause = '0;
  endtask

  task automatic set_lane(input int i, input logic [63:0] pc, input logic [31:0] insn,
                          input logic wen, input logic wfp, input logic [4:0] waddr,
                          input logic [63:0] wdata);
    commit_valid[i]          = 1'b1;
    commit_pc[i*64 +: 64]    = pc;
    commit_insn[i*32 +: 32]  = insn;
    commit_wen[i]            = wen;
    commit_wfp[i]            = wfp;
    commit_waddr[i*5 +: 5]   = waddr;
    commit_wdata[i*64 +: 64] = wdata;
  endtask

  task automatic check_outputs();
    ev_t h;
    check_eq("count", 64'(count), 64'(mq.size()));
    check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("drop_count", 64'(drop_count), 64'(m_drops));
    if (mq.size() != 0) begin
      h = mq[0];
      check_eq("head_kind", 64'(out_kind), 64'(h.kind));
      check_eq("head_pc", out_pc, h.pc);
      check_eq("head_insn", 64'(out_insn), 64'(h.insn));
      check_eq("head_wen", 64'(out_wen), 64'(h.wen));
      check_eq("head_wfp", 64'(out_wfp), 64'(h.wfp));
      check_eq("head_waddr", 64'(out_waddr), 64'(h.waddr));
      check_eq("head_wdata", out_wdata, h.wdata);
    end else begin
      check_eq("empty_payload",
               64'(out_kind) | out_pc | 64'(out_insn) | 64'(out_wen) | 64'(out_wfp)
               | 64'(out_waddr) | out_wdata, 64'd0);
    end
  endtask

  // Check the current state, then advance one clock and apply the same cycle to the model.
  task automatic step();
    ev_t grp[$];
    ev_t e;
    int  sz;
    bit  do_deq;
    check_outputs();
    for (int i = 0; i < int'(COMMITS); i++) begin
      if (commit_valid[i]) begin
        e.kind  = 1'b0;
        e.pc    = commit_pc[i*64 +: 64];
        e.insn  = commit_insn[i*32 +: 32];
        e.wen   = commit_wen[i];
        e.wfp   = commit_wfp[i];
        e.waddr = commit_wen[i] ? commit_waddr[i*5 +: 5] : 5'd0;
        e.wdata = commit_wen[i] ? commit_wdata[i*64 +: 64] : 64'd0;
        grp.push_back(e);
      end
    end
    if (trap_valid) begin
      e.kind = 1'b1; e.pc = '0; e.insn = '0; e.wen = 1'b0; e.wfp = 1'b0;
      e.waddr = '0; e.wdata = trap_cause;
      grp.push_back(e);
    end
    sz     = mq.size();
    do_deq = (sz != 0) && out_ready;
    @(posedge clock);
    if (!reset) begin
      mq.delete();
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      if (do_deq) void'(mq.pop_front());
      if (grp.size() <= int'(DEPTH) - sz) begin
        foreach (grp[k]) mq.push_back(grp[k]);
      end else begin
        m_ovf   = 1;
        m_drops = (m_drops + grp.size() > 65535) ? 65535 : m_drops + grp.size();
      end
    end
    #1;
  endtask

  logic [63:0] first_pc;
  logic [63:0] exp_pc;
  logic [63:0] next_pc;
  int          sent;
  int          got_n;

  initial begin
    reset = 1'b0;
    out_ready = 1'b0;
    clear_inputs();
    mq.delete(); m_ovf = 0; m_drops = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    check_eq("reset_count", 64'(count), 64'd0);
    check_eq("reset_valid", 64'(out_valid), 64'd0);

    // Single lane-0 commit.
    out_ready = 1'b1;
    set_lane(0, 64'h8000_0000, 32'h0050_0093, 1'b1, 1'b0, 5'd1, 64'd5);
    step();
    clear_inputs();
    check_eq("t1_valid", 64'(out_valid), 64'd1);
    check_eq("t1_pc", out_pc, 64'h8000_0000);
    check_eq("t1_insn", 64'(out_insn), 64'h0050_0093);
    check_eq("t1_wdata", out_wdata, 64'd5);
    step();
    check_eq("t1_drained", 64'(count), 64'd0);

    // Two commits plus a trap in one cycle.
    set_lane(0, 64'h100, 32'h11, 1'b1, 1'b0, 5'd3, 64'hAA);
    set_lane(1, 64'h104, 32'h22, 1'b1, 1'b1, 5'd4, 64'hBB);
    trap_valid = 1'b1; trap_cause = 64'd2;
    step();
    clear_inputs();
    check_eq("t2_count", 64'(count), 64'd3);
    step(); step();
    check_eq("t2_trap_kind", 64'(out_kind), 64'd1);
    check_eq("t2_trap_cause", out_wdata, 64'd2);
    step();

    // Lane gap: only lane 1, with wen=0 forcing waddr/wdata to zero.
    set_lane(1, 64'h200, 32'h33, 1'b0, 1'b0, 5'd9, 64'hDEAD);
    step();
    clear_inputs();
    check_eq("t3_count", 64'(count), 64'd1);
    check_eq("t3_pc", out_pc, 64'h200);
    check_eq("t3_wdata_forced", out_wdata, 64'd0);
    step();

    // Fill to capacity with the consumer stalled, then overflow.
    out_ready = 1'b0;
    first_pc = 64'h1000;
    for (int k = 0; k < 9; k++) begin
      set_lane(0, 64'h1000 + 64'(8*k), 32'h13, 1'b1, 1'b0, 5'(k), 64'(k));
      set_lane(1, 64'h1004 + 64'(8*k), 32'h13, 1'b1, 1'b0, 5'(k+1), 64'(k+100));
      step();
    end
    clear_inputs();
    check_eq("full_count", 64'(count), 64'd16);
    check_eq("full_overflow", 64'(overflow), 64'd1);
    check_eq("full_drops", 64'(drop_count), 64'd2);
    check_eq("full_head", out_pc, first_pc);

    // Same-cycle dequeue does not free space for the enqueue.
    out_ready = 1'b1;
    step();
    set_lane(0, 64'h3000, 32'h1, 1'b1, 1'b0, 5'd1, 64'd1);
    set_lane(1, 64'h3004, 32'h2, 1'b1, 1'b0, 5'd2, 64'd2);
    step();
    clear_inputs();
    check_eq("c15_count", 64'(count), 64'd14);
    check_eq("c15_drops", 64'(drop_count), 64'd4);

    // Mid-stream reset at count 5, with an event presented on the reset cycle.
    repeat (9) step();
    check_eq("pre_reset_count", 64'(count), 64'd5);
    reset = 1'b0;
    set_lane(0, 64'h4000, 32'h5, 1'b1, 1'b0, 5'd5, 64'd5);
    step();
    reset = 1'b1;
    clear_inputs();
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_drops", 64'(drop_count), 64'd0);

    // 40 ordered commits across pointer wrap with toggling ready.
    sent = 0; got_n = 0; exp_pc = 64'h8000_0000; next_pc = 64'h8000_0000;
    for (int c = 0; c < 200 && got_n < 40; c++) begin
      clear_inputs();
      out_ready = ~c[0];
      if (!c[0] && sent < 40) begin
        set_lane(0, next_pc, 32'h13, 1'b1, 1'b0, 5'd7, next_pc);
        next_pc = next_pc + 64'd4;
        sent++;
      end
      if (out_valid && out_ready) begin
        check_eq("stream_pc", out_pc, exp_pc);
        exp_pc = exp_pc + 64'd4;
        got_n++;
      end
      step();
    end
    clear_inputs();
    check_eq("stream_total", 64'(got_n), 64'd40);
    check_eq("stream_overflow", 64'(overflow), 64'd0);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 500; c++) begin
      clear_inputs();
      for (int i = 0; i < int'(COMMITS); i++) begin
        if ($urandom_range(1, 0) == 1)
          set_lane(i, {$urandom, $urandom}, $urandom, 1'($urandom), 1'($urandom),
                   5'($urandom), {$urandom, $urandom});
      end
      trap_valid = ($urandom_range(7, 0) == 0);
      trap_cause = 64'($urandom_range(15, 0));
      out_ready  = ($urandom_range(2, 0) == 0);
      reset      = ($urandom_range(149, 0) != 0);
      step();
    end
    reset = 1'b1;
    clear_inputs();
    out_ready = 1'b1;
    repeat (20) step();
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cosim_commit_queue.md
Name: cosim_commit_queue

Overview:
- Producer side of the Spike co-simulation commit interface.
- Captures per-cycle retirement events from the core pipeline: up to COMMITS committed instructions with their register writebacks, plus one trap.
- Serialises them in program order through a FIFO.
- Presents one event per cycle on a valid/ready stream to the testbench DPI consumer, so the checker sees a strictly ordered, lossless (or explicitly flagged) event sequence.

Parameters:
- COMMITS, 2, number of retirement lanes per cycle (1..4).
- XLEN, 64, PC/data/cause width.
- DEPTH, 16, FIFO entries; power of two, must be >= COMMITS+1.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clock).
- commit_valid  in  COMMITS  per-lane retire strobe; lane i packed at bit i.
- commit_pc  in  COMMITS*XLEN  per-lane PC.
- commit_insn  in  COMMITS*32  per-lane instruction word.
- commit_wen  in  COMMITS  per-lane register write enable.
- commit_wfp  in  COMMITS  per-lane write targets FP file (1) or integer file (0).
- commit_waddr  in  COMMITS*5  per-lane destination register.
- commit_wdata  in  COMMITS*XLEN  per-lane writeback data.
- trap_valid  in  1  trap taken this cycle.
- trap_cause  in  XLEN  trap cause (mcause encoding).
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_kind  out  1  0 = commit, 1 = trap.
- out_pc  out  XLEN  commit PC (0 for trap).
- out_insn  out  32  instruction (0 for trap).
- out_wen  out  1  writeback present.
- out_wfp  out  1  FP destination.
- out_waddr  out  5  destination register.
- out_wdata  out  XLEN  writeback data; carries cause when out_kind=1.
- count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one cycle's events were dropped.
- drop_count  out  16  number of dropped events, saturating at 0xFFFF.

Behaviour:
- Reset:
  - Pointers, count, overflow and drop_count clear to 0; out_valid=0.
  - All out_* payload signals read 0 while empty.
  - Reset asserted mid-stream flushes the FIFO at that edge; events presented on the reset cycle are discarded and not counted.
- Enqueue grouping:
  - Per cycle, n = popcount(commit_valid) + trap_valid events.
  - Valid lanes are compacted in ascending lane index; lane gaps are legal.
  - The trap is placed after all commits of the same cycle.
  - Write address advances by n mod DEPTH.
- Admission:
  - Space check uses occupancy at the start of the cycle: free = DEPTH - count.
  - A same-cycle dequeue does not create space for a same-cycle enqueue.
  - If n <= free, all n events are written.
  - Otherwise the whole group is dropped (no partial group), overflow is set, and drop_count += n (saturating).
- Dequeue:
  - out_valid = (count != 0); out_* reflect the head entry combinationally from storage.
  - Transfer occurs when out_valid && out_ready; read pointer advances by 1 with wrap at DEPTH.
  - Payload is stable while out_valid && !out_ready.
- Count update:
  - count_next = count + accepted_n - (out_valid && out_ready).
  - Simultaneous enqueue and dequeue are both honoured.
- Latency: an event presented at edge N is visible on out_* from cycle N+1 at the earliest, when the FIFO was empty.
- out_ready while empty: ignored.
- Inputs with commit_wen=0: out_waddr and out_wdata are forced to 0 on output.
- overflow is cleared only by reset.

Test Plan:
- Single lane 0 commit: pc=0x80000000, insn=0x00500093, wen=1, waddr=1, wdata=5, out_ready=1 -> next cycle out_valid=1, kind=0, same fields; count returns to 0 after the transfer.
- Lane 0 and lane 1 commits plus trap_valid (cause=2) in one cycle, out_ready=1 -> three consecutive transfers: lane0, lane1, then trap (kind=1, wdata=2).
- Only lane 1 valid (gap at lane 0) -> a single entry carrying lane 1 fields; count=1.
- out_ready=0, 8 cycles of two commits -> count=16. A further 2-commit cycle -> dropped, overflow=1, drop_count=2. Head remains the first entry, unchanged.
- At count=15 with out_ready=1 and a 2-commit enqueue in the same cycle -> dropped (free=1 < 2); count=14 after the edge; drop_count increments by 2.
- Stream 40 single commits with pc incrementing by 4, out_ready toggling 1/0 -> all 40 emerge in order across pointer wrap; overflow stays 0.
- reset=0 for one cycle while count=5 -> count=0, out_valid=0 next cycle, overflow=0, drop_count=0.
